pipeline_memory_access: RTL and testbench
=========================================

// Module: pipeline_memory_access
// PURPOSE
//  MEM stage of the 5-stage RV32 pipeline. Takes EX/MEM operands, runs load/store on the data-memory
//  req/ack bus, aligns and sign-extends load data, and drives the registered MEM/WB bundle that
//  feeds the writeback stage (mem data, ALU result, pcsrc, offset, dmem_to_reg select).
//  Stalls upstream while a bus access is outstanding. Flags misaligned accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles dmem_req_o waits for dmem_ack_i; 0 = no timeout
// PORTS
//  clk_i            in   1   clock, all state on rising edge
//  reset_i          in   1   synchronous, active-high reset
//  ex_valid_i       in   1   EX/MEM bundle valid
//  alu_result_i     in   32  ALU result; byte address for loads/stores
//  store_data_i     in   32  rs2 value for stores
//  mem_read_i       in   1   load
//  mem_write_i      in   1   store (mem_read_i & mem_write_i both high = illegal)
//  funct3_i         in   3   access size/sign
//  pcsrc_i          in   32  pc+4 passthrough
//  offset_i         in   32  sign-extended immediate passthrough
//  dmem_to_reg_i    in   2   writeback mux select passthrough
//  rd_i             in   5   destination register
//  reg_write_i      in   1   register write enable
//  stall_o          out  1   upstream must hold its bundle
//  dmem_req_o       out  1   bus request, held until ack or timeout
//  dmem_we_o        out  1   1 = store
//  dmem_addr_o      out  32  word address ({addr[31:2],2'b00})
//  dmem_be_o        out  4   byte enables
//  dmem_wdata_o     out  32  lane-replicated store data
//  dmem_ack_i       in   1   one-cycle completion; rdata valid same cycle
//  dmem_rdata_i     in   32  load word
//  wb_valid_o       out  1   MEM/WB bundle valid
//  mem_data_read_o  out  32  aligned, extended load data (0 for non-loads)
//  alu_result_o / pcsrc_o / offset_o  out 32 each; dmem_to_reg_o out 2; rd_o out 5; reg_write_o out 1
//  exc_misalign_o   out  1   pulse: misaligned/illegal access
//  bus_err_o        out  1   pulse: bus timeout
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-access drops dmem_req_o at that
//   edge, discards the access, no wb_valid_o produced; late ack after reset is ignored.
//  FSM IDLE/WAIT. stall_o = (state==WAIT). Input sampled only in IDLE.
//  IDLE, ex_valid_i, no memop: MEM/WB regs load next edge, wb_valid_o=1 (latency 1), mem_data_read_o=0.
//  IDLE, legal memop: capture bundle, -> WAIT; dmem_req_o/we/addr/be/wdata registered, valid from next cycle.
//  WAIT: hold bus outputs stable. On dmem_ack_i: MEM/WB load, wb_valid_o=1 next cycle, -> IDLE,
//   dmem_req_o=0 next cycle. Min memop latency 2 cycles (ack in first req cycle).
//  Timeout: counter increments each WAIT cycle without ack; at TIMEOUT_CYCLES -> IDLE, req dropped,
//   wb_valid_o=1 with reg_write_o=0 and bus_err_o=1 for one cycle. Ack on the expiry cycle wins.
//  Sizes: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only).
//   Load: select lane by addr[1:0], sign-extend (B,H) or zero-extend (BU,HU).
//   Store: be = 0001<<a (B), 0011<<a (H), 1111 (W); wdata = {4{b}}, {2{h}}, or word.
//  Misaligned (H at a[0]=1, W at a[1:0]!=0) or illegal funct3/read&write: no bus request; next cycle
//   wb_valid_o=1, reg_write_o=0, exc_misalign_o=1, alu_result_o = faulting address.
//  wb_valid_o, exc_misalign_o, bus_err_o are 1-cycle pulses; data outputs hold until next load.
// TESTING
//  ALU op rd=5, alu_result=0x1234 -> next cycle wb_valid_o=1, alu_result_o=0x1234, stall_o never high.
//  LB addr 0x103, rdata 0x80FF_0000, ack after 2 cycles -> be=1111, mem_data_read_o=0xFFFF_FF80.
//  SH addr 0x102, data 0xABCD1234, ack immediate -> be=1100, wdata=0x12341234, wb 2 cycles after issue.
//  LW addr 0x101 -> no dmem_req_o, exc_misalign_o=1, reg_write_o=0, alu_result_o=0x101.
//  LW with no ack, TIMEOUT_CYCLES=16 -> req high 16 cycles, bus_err_o pulse, stall_o released.
//  reset_i during WAIT then late ack -> req low after edge, no wb_valid_o, next op works.

Source files
------------

// File: rtl/pipeline_memory_access.sv
// MEM stage of the RV32 pipeline: issues loads/stores on the req/ack data bus,
// aligns load data and drives the registered MEM/WB bundle.
module pipeline_memory_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        ex_valid_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] pcsrc_i,
    input  logic [31:0] offset_i,
    input  logic [1:0]  dmem_to_reg_i,
    input  logic [4:0]  rd_i,
    input  logic        reg_write_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic [31:0] mem_data_read_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] pcsrc_o,
    output logic [31:0] offset_o,
    output logic [1:0]  dmem_to_reg_o,
    output logic [4:0]  rd_o,
    output logic        reg_write_o,
    output logic        exc_misalign_o,
    output logic        bus_err_o
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state, next_state;
    logic [TW-1:0] timer;

    logic          is_memop, bad_access, load_ok, store_ok, misalign;
    logic          start_access, timed_out;
    logic [3:0]    store_be;
    logic [31:0]   store_wdata;
    logic [31:0]   shifted_rdata, load_data;

    logic          cap_is_load, cap_reg_write;
    logic [2:0]    cap_funct3;
    logic [1:0]    cap_off, cap_to_reg;
    logic [31:0]   cap_alu, cap_pcsrc, cap_offset;
    logic [4:0]    cap_rd;

    assign stall_o = (state == WAIT);

    // Decode the incoming access and pick the next FSM state.
    always_comb begin
        is_memop     = mem_read_i | mem_write_i;
        load_ok      = 1'b0;
        store_ok     = 1'b0;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: begin load_ok = 1'b1; store_ok = 1'b1; end
            3'b100, 3'b101:         load_ok = 1'b1;
            default:                ;
        endcase
        misalign     = ((funct3_i[1:0] == 2'b01) && alu_result_i[0]) ||
                       ((funct3_i[1:0] == 2'b10) && (alu_result_i[1:0] != 2'b00));
        bad_access   = (mem_read_i & mem_write_i) | (mem_read_i & ~load_ok) |
                       (mem_write_i & ~store_ok) | misalign;
        start_access = (state == IDLE) && ex_valid_i && is_memop && !bad_access;
        timed_out    = (TIMEOUT_CYCLES != 0) && !dmem_ack_i &&
                       (timer == TW'(TIMEOUT_CYCLES - 1));
        next_state   = state;
        case (state)
            IDLE: if (start_access) next_state = WAIT;
            WAIT: if (dmem_ack_i || timed_out) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Byte lanes: stores replicate data across lanes, loads always read the full word.
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = store_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                store_be    = 4'b0001 << alu_result_i[1:0];
                store_wdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                store_be    = 4'b0011 << alu_result_i[1:0];
                store_wdata = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
        if (!mem_write_i) store_be = 4'b1111;
    end

    always_comb begin
        shifted_rdata = dmem_rdata_i >> {cap_off, 3'b000};
        case (cap_funct3)
            3'b000:  load_data = {{24{shifted_rdata[7]}}, shifted_rdata[7:0]};
            3'b001:  load_data = {{16{shifted_rdata[15]}}, shifted_rdata[15:0]};
            3'b100:  load_data = {24'd0, shifted_rdata[7:0]};
            3'b101:  load_data = {16'd0, shifted_rdata[15:0]};
            default: load_data = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= next_state;
    end

    // Bus side and MEM/WB bundle; pulses default low every cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timer           <= '0;
            dmem_req_o      <= 1'b0;
            dmem_we_o       <= 1'b0;
            dmem_addr_o     <= '0;
            dmem_be_o       <= '0;
            dmem_wdata_o    <= '0;
            wb_valid_o      <= 1'b0;
            mem_data_read_o <= '0;
            alu_result_o    <= '0;
            pcsrc_o         <= '0;
            offset_o        <= '0;
            dmem_to_reg_o   <= '0;
            rd_o            <= '0;
            reg_write_o     <= 1'b0;
            exc_misalign_o  <= 1'b0;
            bus_err_o       <= 1'b0;
            cap_is_load     <= 1'b0;
            cap_reg_write   <= 1'b0;
            cap_funct3      <= '0;
            cap_off         <= '0;
            cap_to_reg      <= '0;
            cap_alu         <= '0;
            cap_pcsrc       <= '0;
            cap_offset      <= '0;
            cap_rd          <= '0;
        end else begin
            wb_valid_o     <= 1'b0;
            exc_misalign_o <= 1'b0;
            bus_err_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid_i && (!is_memop || bad_access)) begin
                        wb_valid_o      <= 1'b1;
                        mem_data_read_o <= '0;
                        alu_result_o    <= alu_result_i;
                        pcsrc_o         <= pcsrc_i;
                        offset_o        <= offset_i;
                        dmem_to_reg_o   <= dmem_to_reg_i;
                        rd_o            <= rd_i;
                        reg_write_o     <= reg_write_i & ~is_memop;
                        exc_misalign_o  <= is_memop;
                    end else if (start_access) begin
                        timer         <= '0;
                        dmem_req_o    <= 1'b1;
                        dmem_we_o     <= mem_write_i;
                        dmem_addr_o   <= {alu_result_i[31:2], 2'b00};
                        dmem_be_o     <= store_be;
                        dmem_wdata_o  <= store_wdata;
                        cap_is_load   <= mem_read_i;
                        cap_reg_write <= reg_write_i;
                        cap_funct3    <= funct3_i;
                        cap_off       <= alu_result_i[1:0];
                        cap_to_reg    <= dmem_to_reg_i;
                        cap_alu       <= alu_result_i;
                        cap_pcsrc     <= pcsrc_i;
                        cap_offset    <= offset_i;
                        cap_rd        <= rd_i;
                    end
                end
                WAIT: begin
                    if (dmem_ack_i || timed_out) begin
                        dmem_req_o      <= 1'b0;
                        wb_valid_o      <= 1'b1;
                        bus_err_o       <= ~dmem_ack_i;
                        mem_data_read_o <= (dmem_ack_i && cap_is_load) ? load_data : 32'd0;
                        reg_write_o     <= cap_reg_write & dmem_ack_i;
                        alu_result_o    <= cap_alu;
                        pcsrc_o         <= cap_pcsrc;
                        offset_o        <= cap_offset;
                        dmem_to_reg_o   <= cap_to_reg;
                        rd_o            <= cap_rd;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_memory_access.sv
// Directed-vector bench for the MEM stage: ALU passthrough, loads/stores,
// misalignment, bus timeout and reset during an outstanding access.
module tb_pipeline_memory_access;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        ex_valid_i = 1'b0;
    logic [31:0] alu_result_i = '0;
    logic [31:0] store_data_i = '0;
    logic        mem_read_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] pcsrc_i = 32'h0000_0044;
    logic [31:0] offset_i = 32'h0000_0010;
    logic [1:0]  dmem_to_reg_i = 2'b01;
    logic [4:0]  rd_i = '0;
    logic        reg_write_i = 1'b0;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        wb_valid_o;
    logic [31:0] mem_data_read_o, alu_result_o, pcsrc_o, offset_o;
    logic [1:0]  dmem_to_reg_o;
    logic [4:0]  rd_o;
    logic        reg_write_o, exc_misalign_o, bus_err_o;

    int tests_run = 0;
    int tests_failed = 0;

    pipeline_memory_access #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .ex_valid_i(ex_valid_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
        .pcsrc_i(pcsrc_i), .offset_i(offset_i), .dmem_to_reg_i(dmem_to_reg_i),
        .rd_i(rd_i), .reg_write_i(reg_write_i), .stall_o(stall_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o),
        .mem_data_read_o(mem_data_read_o), .alu_result_o(alu_result_o),
        .pcsrc_o(pcsrc_o), .offset_o(offset_o), .dmem_to_reg_o(dmem_to_reg_o),
        .rd_o(rd_o), .reg_write_o(reg_write_o), .exc_misalign_o(exc_misalign_o),
        .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Presents one EX/MEM bundle for a single edge, then withdraws it.
    task automatic applyStimulus(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [4:0] rd, input logic rw);
        ex_valid_i   = 1'b1;
        mem_read_i   = rd_en;
        mem_write_i  = wr_en;
        funct3_i     = f3;
        alu_result_i = addr;
        store_data_i = sdata;
        rd_i         = rd;
        reg_write_i  = rw;
        tick();
        ex_valid_i   = 1'b0;
        mem_read_i   = 1'b0;
        mem_write_i  = 1'b0;
    endtask

    task automatic immediateLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] rdata, input logic [31:0] expected);
        applyStimulus(1'b1, 1'b0, f3, addr, 32'd0, 5'd7, 1'b1);
        checkOutput({tag, "_req"}, {31'd0, dmem_req_o}, 32'd1);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rdata;
        tick();
        dmem_ack_i   = 1'b0;
        checkOutput({tag, "_wb"}, {31'd0, wb_valid_o}, 32'd1);
        checkOutput({tag, "_data"}, mem_data_read_o, expected);
    endtask

    int req_cycles;

    initial begin
        tick();
        tick();
        checkOutput("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        checkOutput("rst_req", {31'd0, dmem_req_o}, 32'd0);
        checkOutput("rst_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("rst_alu", alu_result_o, 32'd0);
        reset_i = 1'b0;
        tick();

        // ALU-only instruction: one-cycle passthrough, no stall
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h1234, 32'd0, 5'd5, 1'b1);
        checkOutput("alu_wb_valid", {31'd0, wb_valid_o}, 32'd1);
        checkOutput("alu_result", alu_result_o, 32'h1234);
        checkOutput("alu_rd", {27'd0, rd_o}, 32'd5);
        checkOutput("alu_reg_write", {31'd0, reg_write_o}, 32'd1);
        checkOutput("alu_pcsrc", pcsrc_o, 32'h44);
        checkOutput("alu_mem_data", mem_data_read_o, 32'd0);
        checkOutput("alu_stall", {31'd0, stall_o}, 32'd0);
        tick();
        checkOutput("alu_wb_pulse", {31'd0, wb_valid_o}, 32'd0);

        // LB 0x103, ack on the second wait cycle
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 5'd3, 1'b1);
        checkOutput("lb_req", {31'd0, dmem_req_o}, 32'd1);
        checkOutput("lb_we", {31'd0, dmem_we_o}, 32'd0);
        checkOutput("lb_addr", dmem_addr_o, 32'h100);
        checkOutput("lb_be", {28'd0, dmem_be_o}, 32'hF);
        checkOutput("lb_stall", {31'd0, stall_o}, 32'd1);
        tick();
        checkOutput("lb_req_hold", {31'd0, dmem_req_o}, 32'd1);
        checkOutput("lb_no_wb", {31'd0, wb_valid_o}, 32'd0);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h80FF_0000;
        tick();
        dmem_ack_i = 1'b0;
        checkOutput("lb_wb_valid", {31'd0, wb_valid_o}, 32'd1);
        checkOutput("lb_data", mem_data_read_o, 32'hFFFF_FF80);
        checkOutput("lb_req_drop", {31'd0, dmem_req_o}, 32'd0);
        checkOutput("lb_stall_rel", {31'd0, stall_o}, 32'd0);
        checkOutput("lb_rd", {27'd0, rd_o}, 32'd3);

        // SH 0x102, immediate ack
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h102, 32'hABCD_1234, 5'd0, 1'b0);
        checkOutput("sh_we", {31'd0, dmem_we_o}, 32'd1);
        checkOutput("sh_be", {28'd0, dmem_be_o}, 32'hC);
        checkOutput("sh_wdata", dmem_wdata_o, 32'h1234_1234);
        checkOutput("sh_addr", dmem_addr_o, 32'h100);
        dmem_ack_i = 1'b1;
        tick();
        dmem_ack_i = 1'b0;
        checkOutput("sh_wb_valid", {31'd0, wb_valid_o}, 32'd1);
        checkOutput("sh_mem_data", mem_data_read_o, 32'd0);

        // SB 0x101 lane enable and replication
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_0055, 5'd0, 1'b0);
        checkOutput("sb_be", {28'd0, dmem_be_o}, 32'h2);
        checkOutput("sb_wdata", dmem_wdata_o, 32'h5555_5555);
        dmem_ack_i = 1'b1;
        tick();
        dmem_ack_i = 1'b0;

        immediateLoad("lhu", 3'b101, 32'h102, 32'h8765_4321, 32'h0000_8765);
        immediateLoad("lh", 3'b001, 32'h000, 32'h0000_F00D, 32'hFFFF_F00D);
        immediateLoad("lbu", 3'b100, 32'h001, 32'h0000_9A00, 32'h0000_009A);
        immediateLoad("lw", 3'b010, 32'h204, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Misaligned LW
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 5'd9, 1'b1);
        checkOutput("mis_req", {31'd0, dmem_req_o}, 32'd0);
        checkOutput("mis_exc", {31'd0, exc_misalign_o}, 32'd1);
        checkOutput("mis_wb", {31'd0, wb_valid_o}, 32'd1);
        checkOutput("mis_reg_write", {31'd0, reg_write_o}, 32'd0);
        checkOutput("mis_addr", alu_result_o, 32'h101);
        checkOutput("mis_stall", {31'd0, stall_o}, 32'd0);
        tick();
        checkOutput("mis_exc_pulse", {31'd0, exc_misalign_o}, 32'd0);

        // Illegal: read and write together; store with unsigned size
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h100, 32'd0, 5'd1, 1'b1);
        checkOutput("rw_exc", {31'd0, exc_misalign_o}, 32'd1);
        checkOutput("rw_req", {31'd0, dmem_req_o}, 32'd0);
        applyStimulus(1'b0, 1'b1, 3'b100, 32'h100, 32'd0, 5'd0, 1'b0);
        checkOutput("sbu_exc", {31'd0, exc_misalign_o}, 32'd1);

        // Timeout: no ack, request must stay up exactly 16 cycles
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 5'd4, 1'b1);
        req_cycles = 0;
        while (dmem_req_o && req_cycles < 40) begin
            req_cycles++;
            tick();
        end
        checkOutput("to_req_cycles", req_cycles, 32'd16);
        checkOutput("to_bus_err", {31'd0, bus_err_o}, 32'd1);
        checkOutput("to_wb", {31'd0, wb_valid_o}, 32'd1);
        checkOutput("to_reg_write", {31'd0, reg_write_o}, 32'd0);
        checkOutput("to_stall", {31'd0, stall_o}, 32'd0);
        tick();
        checkOutput("to_err_pulse", {31'd0, bus_err_o}, 32'd0);

        // Reset while waiting, then a late ack is ignored
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 5'd6, 1'b1);
        checkOutput("rw_wait_req", {31'd0, dmem_req_o}, 32'd1);
        reset_i = 1'b1;
        tick();
        checkOutput("rstw_req", {31'd0, dmem_req_o}, 32'd0);
        checkOutput("rstw_wb", {31'd0, wb_valid_o}, 32'd0);
        checkOutput("rstw_stall", {31'd0, stall_o}, 32'd0);
        reset_i      = 1'b0;
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h1111_1111;
        tick();
        dmem_ack_i = 1'b0;
        checkOutput("late_ack_wb", {31'd0, wb_valid_o}, 32'd0);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h55AA, 32'd0, 5'd2, 1'b1);
        checkOutput("post_rst_wb", {31'd0, wb_valid_o}, 32'd1);
        checkOutput("post_rst_alu", alu_result_o, 32'h55AA);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
